pmem_responder: RTL and testbench



---
 rtl/pmem_responder_if.sv | 21 ++
 rtl/pmem_responder.sv | 142 ++++++++++++++
 tb/tb_pmem_responder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pmem_responder_if.sv
// Line-granular physical-memory bus between the cache arbiter (master)
// and a pmem responder (slave).
interface pmem_responder_if;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;
  logic         busy;

  modport master (
    output pmem_address, pmem_read, pmem_write, pmem_wdata,
    input  pmem_resp, pmem_rdata, busy
  );

  modport slave (
    input  pmem_address, pmem_read, pmem_write, pmem_wdata,
    output pmem_resp, pmem_rdata, busy
  );
endinterface

// File: rtl/pmem_responder.sv
// Fixed-latency physical-memory responder: one 16-byte line transaction at a
// time, completed with a single-cycle pmem_resp LATENCY cycles after acceptance.
module pmem_responder_chk #(
  parameter int    LATENCY   = 4,
  parameter string INIT_FILE = ""
) (
  input logic clk,
  input logic reset,
  input logic pmem_resp
);
  if (LATENCY < 1 || LATENCY > 255) begin : g_latency_range
    $fatal(1, "pmem_responder: LATENCY %0d outside 1..255", LATENCY);
  end

  if (INIT_FILE != "") begin : g_init_file
    $info("pmem_responder: line image %s is preloaded by the simulation harness", INIT_FILE);
  end

  // A completion is always a single-cycle pulse.
  assert property (@(posedge clk) disable iff (reset) !(pmem_resp && $past(pmem_resp)))
    else $error("pmem_responder: pmem_resp high on consecutive cycles");
endmodule

module pmem_responder #(
  parameter int    LATENCY       = 4,
  parameter int    LINE_IDX_BITS = 12,
  parameter string INIT_FILE     = ""
) (
  input logic             clk,
  input logic             reset,
  pmem_responder_if.slave bus
);
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                   state_r, state_s;
  logic [7:0]               count_r, count_s;
  logic [LINE_IDX_BITS-1:0] idx_r, addr_idx_s, rd_idx_s;
  logic                     is_write_r;
  logic [127:0]             wdata_r, rdata_r;
  logic                     resp_r, busy_r;
  logic                     accept_s, load_rdata_s, commit_s;
  logic                     addr_unused_s;
  logic [127:0]             mem_r [2**LINE_IDX_BITS];

  assign addr_idx_s    = bus.pmem_address[LINE_IDX_BITS+3:4];
  assign addr_unused_s = ^bus.pmem_address[3:0];
  // With LATENCY=1 the array is read in the accepting cycle, before idx_r is loaded.
  assign rd_idx_s      = (state_r == ST_IDLE) ? addr_idx_s : idx_r;
  assign commit_s      = (state_r == ST_RESP) && is_write_r && !reset;

  // Next-state, countdown and acceptance decode
  always_comb begin
    state_s      = state_r;
    count_s      = count_r;
    accept_s     = 1'b0;
    load_rdata_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.pmem_read || bus.pmem_write) begin
          accept_s = 1'b1;
          count_s  = LAT_M1;
          if (LATENCY == 1) begin
            state_s      = ST_RESP;
            load_rdata_s = !bus.pmem_write;
          end else begin
            state_s = ST_WAIT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        count_s = count_r - 8'd1;
        if (count_r == 8'd1) begin
          state_s      = ST_RESP;
          load_rdata_s = !is_write_r;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
        count_s = 8'd0;
      end
      default: begin
        state_s = ST_IDLE;
        count_s = 8'd0;
      end
    endcase
  end

  // FSM state, request latches and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      count_r    <= 8'd0;
      idx_r      <= {LINE_IDX_BITS{1'b0}};
      is_write_r <= 1'b0;
      wdata_r    <= 128'd0;
      rdata_r    <= 128'd0;
      resp_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      if (accept_s) begin
        idx_r      <= addr_idx_s;
        is_write_r <= bus.pmem_write;
        wdata_r    <= bus.pmem_wdata;
      end
      if (load_rdata_s) begin
        rdata_r <= mem_r[rd_idx_s];
      end
      resp_r <= (state_s == ST_RESP);
      busy_r <= (state_s != ST_IDLE);
    end
  end

  // Line array is not reset; a write commits at the end of its RESP cycle
  always_ff @(posedge clk) begin
    if (commit_s) begin
      mem_r[idx_r] <= wdata_r;
    end
  end

  // Reset in the RESP cycle must hide the completion already in flight.
  assign bus.pmem_resp  = resp_r & ~reset;
  assign bus.pmem_rdata = rdata_r;
  assign bus.busy       = busy_r;

  pmem_responder_chk #(.LATENCY(LATENCY), .INIT_FILE(INIT_FILE)) u_chk (
    .clk      (clk),
    .reset    (reset),
    .pmem_resp(bus.pmem_resp)
  );
endmodule

// File: tb/tb_pmem_responder.sv
// Self-checking bench for pmem_responder: a LATENCY=4 and a LATENCY=1 instance
// against a line-map reference model, directed scenarios plus random traffic.
module tb_pmem_responder;
  localparam int LAT = 4;
  localparam int WIN = LAT + 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset1 = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  logic [127:0] ref_mem [logic [12:0]];
  logic [127:0] ref_rdata [2];

  logic [15:0]  seen;
  logic [127:0] rd_at;
  logic [127:0] wd_b;
  bit           r_sel;
  logic [11:0]  r_line;
  logic [15:0]  r_addr, r_alt;
  logic         r_rd, r_wr;
  logic [127:0] r_wd;

  always #5 clk = ~clk;

  pmem_responder_if bus0 ();
  pmem_responder_if bus1 ();

  pmem_responder #(.LATENCY(LAT), .LINE_IDX_BITS(12), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  pmem_responder #(.LATENCY(1), .LINE_IDX_BITS(12), .INIT_FILE("")) dut1 (
    .clk(clk), .reset(reset1), .bus(bus1)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic [15:0] a, input logic rd, input logic wr,
                       input logic [127:0] wd);
    if (sel) begin
      bus1.pmem_address = a; bus1.pmem_read = rd; bus1.pmem_write = wr; bus1.pmem_wdata = wd;
    end else begin
      bus0.pmem_address = a; bus0.pmem_read = rd; bus0.pmem_write = wr; bus0.pmem_wdata = wd;
    end
  endtask

  // {resp, busy, rdata} of the selected instance
  function automatic logic [129:0] sample(input bit sel);
    return sel ? {bus1.pmem_resp, bus1.busy, bus1.pmem_rdata}
               : {bus0.pmem_resp, bus0.busy, bus0.pmem_rdata};
  endfunction

  task automatic check_quiet(input bit sel, input string tag);
    logic [129:0] s;
    s = sample(sel);
    check($sformatf("%s resp", tag), 128'(s[129]), 128'd0);
    check($sformatf("%s busy", tag), 128'(s[128]), 128'd0);
    check($sformatf("%s rdata", tag), s[127:0], ref_rdata[sel]);
  endtask

  // One transaction as the arbiter drives it: held until resp, dropped the cycle after.
  task automatic txn(input bit sel, input string tag, input logic [15:0] a, input logic [15:0] alt,
                     input logic rd, input logic wr, input logic [127:0] wd);
    int lat, resp_cyc;
    logic [15:0] rs, bs;
    logic [127:0] at_resp, exp_rdata;
    logic [12:0] key;
    logic [129:0] s;
    lat = sel ? 1 : LAT;
    resp_cyc = -1; rs = 16'd0; bs = 16'd0; at_resp = 128'd0;
    key = {sel, a[15:4]};
    if (wr) exp_rdata = ref_rdata[sel];
    else if (ref_mem.exists(key)) exp_rdata = ref_mem[key];
    else exp_rdata = 128'd0;
    @(posedge clk); #1;
    drive(sel, a, rd, wr, wd);
    for (int c = 0; c < WIN; c++) begin
      @(negedge clk);
      s = sample(sel);
      rs[c] = s[129];
      bs[c] = s[128];
      if (s[129] && resp_cyc < 0) begin
        resp_cyc = c;
        at_resp = s[127:0];
      end
      @(posedge clk); #1;
      if (c == 0 && alt != a) drive(sel, alt, rd, wr, ~wd);
      if (c == resp_cyc) drive(sel, a, 1'b0, 1'b0, wd);
    end
    drive(sel, a, 1'b0, 1'b0, wd);
    check($sformatf("%s resp_cycles", tag), 128'(rs), 128'(16'd1 << lat));
    check($sformatf("%s busy_cycles", tag), 128'(bs), 128'(((16'd1 << lat) - 16'd1) << 1));
    check($sformatf("%s rdata_at_resp", tag), at_resp, exp_rdata);
    if (wr) ref_mem[key] = wd;
    else ref_rdata[sel] = exp_rdata;
    s = sample(sel);
    check($sformatf("%s rdata_held", tag), s[127:0], ref_rdata[sel]);
  endtask

  // Write to dut that is cut short by reset asserted during cycle rst_cyc.
  task automatic aborted_write(input string tag, input logic [15:0] a, input logic [127:0] wd,
                               input int rst_cyc);
    logic [15:0] rs;
    rs = 16'd0;
    @(posedge clk); #1;
    drive(1'b0, a, 1'b0, 1'b1, wd);
    for (int c = 0; c < WIN; c++) begin
      @(negedge clk);
      rs[c] = bus0.pmem_resp;
      @(posedge clk); #1;
      if (c + 1 == rst_cyc) begin
        reset = 1'b1;
        drive(1'b0, a, 1'b0, 1'b0, wd);
      end else begin
        reset = 1'b0;
      end
    end
    ref_rdata[0] = 128'd0;
    check($sformatf("%s no_resp", tag), 128'(rs), 128'd0);
    check_quiet(1'b0, tag);
  endtask

  initial begin
    ref_rdata[0] = 128'd0;
    ref_rdata[1] = 128'd0;
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 128'd0);
    drive(1'b1, 16'h0000, 1'b0, 1'b0, 128'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    reset1 = 1'b0;
    @(negedge clk);
    check_quiet(1'b0, "reset0");
    check_quiet(1'b1, "reset1");

    // LATENCY=1 instance: preload the line, then read it back
    txn(1'b1, "l1_preload", 16'h1230, 16'h1230, 1'b0, 1'b1, 128'hDEAD_BEEF);
    txn(1'b1, "l1_read", 16'h1230, 16'h1230, 1'b1, 1'b0, 128'd0);

    txn(1'b0, "wr_0040", 16'h0040, 16'h0040, 1'b0, 1'b1, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
    txn(1'b0, "rd_004C", 16'h004C, 16'h004C, 1'b1, 1'b0, 128'd0);

    txn(1'b0, "rdwr_0080", 16'h0080, 16'h0080, 1'b1, 1'b1, 128'hAA);
    txn(1'b0, "rd_0080", 16'h0080, 16'h0080, 1'b1, 1'b0, 128'd0);

    txn(1'b0, "wr_0500", 16'h0500, 16'h0500, 1'b0, 1'b1, 128'h5005_5005);
    txn(1'b0, "wr_0400", 16'h0400, 16'h0400, 1'b0, 1'b1, 128'h4004_4004);
    txn(1'b0, "rd_0500_moved", 16'h0500, 16'h0400, 1'b1, 1'b0, 128'd0);

    // Arbiter back-to-back: icache read 0x0100, dcache write 0x0200 three cycles after
    txn(1'b0, "wr_0100", 16'h0100, 16'h0100, 1'b0, 1'b1, 128'h0100_CAFE);
    wd_b = 128'h0200_F00D_0200_F00D;
    seen = 16'd0;
    rd_at = 128'd0;
    @(posedge clk); #1;
    for (int c = 0; c < 15; c++) begin
      drive(1'b0, (c <= 4) ? 16'h0100 : 16'h0200, c <= 4, (c >= 7) && (c <= 11), wd_b);
      @(negedge clk);
      seen[c] = bus0.pmem_resp;
      if (c == 4) rd_at = bus0.pmem_rdata;
      @(posedge clk); #1;
    end
    drive(1'b0, 16'h0200, 1'b0, 1'b0, wd_b);
    check("b2b resp_cycles", 128'(seen), 128'((16'd1 << 4) | (16'd1 << 11)));
    check("b2b icache_rdata", rd_at, ref_mem[{1'b0, 12'h010}]);
    ref_rdata[0] = ref_mem[{1'b0, 12'h010}];
    ref_mem[{1'b0, 12'h020}] = wd_b;
    txn(1'b0, "rd_0200", 16'h0200, 16'h0200, 1'b1, 1'b0, 128'd0);

    txn(1'b0, "wr_0300_old", 16'h0300, 16'h0300, 1'b0, 1'b1, 128'h0300_0011);
    aborted_write("abort_c2", 16'h0300, 128'h55, 2);
    txn(1'b0, "rd_0300", 16'h0300, 16'h0300, 1'b1, 1'b0, 128'd0);

    txn(1'b0, "wr_0310_old", 16'h0310, 16'h0310, 1'b0, 1'b1, 128'h0310_0022);
    aborted_write("abort_resp", 16'h0310, 128'h66, LAT);
    txn(1'b0, "rd_0310", 16'h0310, 16'h0310, 1'b1, 1'b0, 128'd0);

    // Random traffic over a small line pool on both instances
    for (int i = 0; i < 40; i++) begin
      r_sel  = ($urandom_range(0, 3) == 0);
      r_line = 12'h060 + 12'($urandom_range(0, 7));
      r_addr = {r_line, 4'($urandom_range(0, 15))};
      r_wr   = !ref_mem.exists({r_sel, r_line}) || ($urandom_range(0, 1) == 1);
      r_rd   = !r_wr || ($urandom_range(0, 3) == 0);
      r_wd   = {$urandom, $urandom, $urandom, $urandom};
      r_alt  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : r_addr;
      txn(r_sel, $sformatf("rand%0d", i), r_addr, r_alt, r_rd, r_wr, r_wd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
